// File: rtl/load_extend_ctrl.sv
// Load sequencer: issues a word-aligned memory read, then selects the addressed
// byte/halfword lane and sign- or zero-extends it into a registered result.
module load_extend_ctrl #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic [1:0]        res_err,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for a load request, ld_ready high
  // REQ    | mem_req held, waiting for mem_ack or timeout
  // RESP   | res_valid held until res_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              w_misaligned;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_ext;

  assign ld_ready = rst_n && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_misaligned = 1'b0;
    case (ld_size)
      2'b01:   w_misaligned = ld_addr[0];
      2'b10:   w_misaligned = |ld_addr[1:0];
      2'b11:   w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  // Timer holds the number of ack-less REQ cycles already completed.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TLIM);

  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{(DWIDTH-8){r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{(DWIDTH-16){r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_lane    <= '0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_valid) begin
            r_lane   <= ld_addr[1:0];
            r_size   <= ld_size;
            r_signed <= ld_signed;
            r_timer  <= '0;
            if (w_misaligned) begin
              r_state   <= S_RESP;
              res_valid <= 1'b1;
              res_err   <= 2'b01;
              res_data  <= '0;
            end else begin
              r_state  <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {ld_addr[AWIDTH-1:2], 2'b00};
            end
          end
        end
        S_REQ: begin
          // An ack on the last allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            r_state   <= S_RESP;
            res_valid <= 1'b1;
            res_err   <= 2'b00;
            res_data  <= w_ext;
          end else if (w_timeout) begin
            mem_req   <= 1'b0;
            r_state   <= S_RESP;
            res_valid <= 1'b1;
            res_err   <= 2'b10;
            res_data  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
